md_pad_responder: RTL and testbench



---
 rtl/md_pad_responder.sv | 104 ++++++++++
 tb/tb_md_pad_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/md_pad_responder.sv
// Mega Drive 3/6-button pad responder: drives active-low DB9 pad pins from the host select line.
// Define MD_SIX_BUTTON_EN for the 6-button pad (phase counter, ID phase, timeout); default is 3-button.
module md_pad_responder #(
  parameter int unsigned TIMEOUT_CYC = 36000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdsel,
  input  logic [11:0] btn,
  output logic [5:0]  pad,
  output logic [2:0]  phase
);

  logic       sel_m;
  logic       sel_s;
  logic       sel_d;
  logic       sel_edge;
  logic       sel_fall;
  logic [2:0] f_use;
  logic [11:0] n;
  logic [5:0] pad_next;

  // Two-stage synchronizer plus a delayed copy for edge detection; all idle high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_m <= 1'b1;
      sel_s <= 1'b1;
      sel_d <= 1'b1;
    end else begin
      sel_m <= mdsel;
      sel_s <= sel_m;
      sel_d <= sel_s;
    end
  end

  assign sel_edge = sel_s ^ sel_d;
  assign sel_fall = sel_d & ~sel_s;

`ifdef MD_SIX_BUTTON_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    f;
  logic [2:0]    f_next;
  logic [TW-1:0] t;
  logic [TW-1:0] t_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      f <= 3'd0;
      t <= '0;
    end else begin
      f <= f_next;
      t <= t_next;
    end
  end

  // A select edge always wins over a coincident timeout expiry.
  always_comb begin
    f_next = f;
    t_next = t;
    if (sel_edge) begin
      t_next = '0;
      if (sel_fall) f_next = (f == 3'd4) ? 3'd1 : f + 3'd1;
    end else if (t == TW'(TIMEOUT_CYC - 1)) begin
      f_next = 3'd0;
      t_next = '0;
    end else if (t != TW'(TIMEOUT_CYC)) begin
      t_next = t + TW'(1);
    end
  end

  assign f_use = f;
  assign phase = f;
`else
  logic unused_six;

  assign unused_six = &{1'b0, btn[11:8], sel_edge, sel_fall};
  assign f_use = 3'd0;
  assign phase = 3'd0;
`endif

  assign n = ~btn;

  // Pin map: pad[0..3]=P1..P4, pad[4]=TL, pad[5]=TR.
  always_comb begin
    pad_next = 6'b111111;
    if (sel_s) begin
      if (f_use == 3'd3) pad_next = {n[6], n[5], n[11], n[8], n[9], n[10]};
      else               pad_next = {n[6], n[5], n[3], n[2], n[1], n[0]};
    end else begin
      case (f_use)
        3'd3:    pad_next = {n[7], n[4], 4'b0000};
        3'd4:    pad_next = {n[7], n[4], 4'b1111};
        default: pad_next = {n[7], n[4], 2'b00, n[1], n[0]};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pad <= 6'b111111;
    else       pad <= pad_next;
  end

endmodule

// File: tb/tb_md_pad_responder.sv
// Directed self-checking bench for md_pad_responder; expectations follow MD_SIX_BUTTON_EN if defined.
module tb_md_pad_responder;

`ifdef MD_SIX_BUTTON_EN
  localparam bit SIX = 1'b1;
`else
  localparam bit SIX = 1'b0;
`endif
  localparam int unsigned TO = 40;

  logic        clk;
  logic        reset;
  logic        mdsel;
  logic [11:0] btn;
  logic [5:0]  pad;
  logic [2:0]  phase;

  int checks;
  int failures;

  md_pad_responder #(.TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .mdsel (mdsel),
    .btn   (btn),
    .pad   (pad),
    .phase (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic half(input logic v, input int cyc);
    mdsel = v;
    tick(cyc);
  endtask

  task automatic reset_dut(input logic sel);
    reset = 1'b1;
    mdsel = sel;
    tick(2);
    reset = 1'b0;
  endtask

  logic [5:0] exp_lo;
  logic [5:0] exp_hi;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    mdsel    = 1'b0;
    btn      = 12'hFFF;

    // Reset while select is low and every button held.
    tick(2);
    check("rst_pad", 12'(pad), 12'h03F);
    check("rst_phase", 12'(phase), 12'h000);
    reset = 1'b0;
    tick(3);
    check("all_pressed_low", 12'(pad), 12'h000);

    // Up + C with select high, then a single-cycle button change, then select low.
    reset_dut(1'b1);
    btn = 12'h041;
    tick(1);
    check("upc_high", 12'(pad), 12'h01E);
    btn = 12'h008;
    tick(1);
    check("btn_latency", 12'(pad), 12'h037);
    btn = 12'h041;
    tick(1);
    check("upc_high_again", 12'(pad), 12'h01E);
    mdsel = 1'b0;
    tick(2);
    check("sel_lat_2", 12'(pad), 12'h01E);
    tick(1);
    check("sel_lat_3", 12'(pad), 12'h032);

    // Four low/high pairs with X + Mode pressed.
    reset_dut(1'b1);
    btn = 12'h900;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      exp_lo = 6'h33;
      exp_hi = 6'h3F;
      if (SIX && i == 2) begin
        exp_lo = 6'h30;
        exp_hi = 6'h33;
      end
      if (SIX && i == 3) exp_lo = 6'h3F;
      half(1'b0, 16);
      check($sformatf("six_lo%0d", i), 12'(pad), 12'(exp_lo));
      check($sformatf("six_phase%0d", i), 12'(phase), SIX ? 12'(i + 1) : 12'h000);
      half(1'b1, 16);
      check($sformatf("six_hi%0d", i), 12'(pad), 12'(exp_hi));
    end

    // Inactivity timeout after two falling edges.
    reset_dut(1'b1);
    tick(4);
    half(1'b0, 8);
    half(1'b1, 8);
    half(1'b0, 8);
    mdsel = 1'b1;
    tick(42);
    check("to_before", 12'(phase), SIX ? 12'h002 : 12'h000);
    tick(1);
    check("to_expired", 12'(phase), 12'h000);
    half(1'b0, 16);
    check("to_lo_pad", 12'(pad), 12'h033);
    check("to_lo_phase", 12'(phase), SIX ? 12'h001 : 12'h000);
    half(1'b1, 16);
    check("to_hi_pad", 12'(pad), 12'h03F);

    // Falling edge detected in the same cycle the timeout would expire.
    reset_dut(1'b1);
    tick(4);
    half(1'b0, 8);
    half(1'b1, 8);
    half(1'b0, 8);
    mdsel = 1'b1;
    tick(40);
    mdsel = 1'b0;
    tick(2);
    check("coinc_before", 12'(phase), SIX ? 12'h002 : 12'h000);
    tick(1);
    check("coinc_edge", 12'(phase), SIX ? 12'h003 : 12'h000);
    tick(1);
    check("coinc_hold", 12'(phase), SIX ? 12'h003 : 12'h000);
    check("coinc_id_pad", 12'(pad), SIX ? 12'h030 : 12'h033);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
